// File: rtl/lap_stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: FSM states, BCD digit limits and the
// 7-segment decode used by the display driver.
package lap_stopwatch_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StPause} sw_state_e;

  // dp lit on h_one, m_one and s_one; bit 7 is digit index 0 (leftmost).
  localparam logic [7:0] SepDpMask = 8'b0101_0100;

  // Maxima of {m_ten, m_one, s_ten, s_one, cc_ten, cc_one}.
  localparam logic [23:0] LowDigitMax = 24'h59_59_99;
  localparam logic [3:0]  DecDigitMax = 4'd9;
  localparam logic [3:0]  HourTenMax  = 4'd2;
  localparam logic [3:0]  HourOneWrap = 4'd3;

  // Returns {a,b,c,d,e,f,g}; codes 10..15 blank the digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b111_1110;
      4'd1:    seg = 7'b011_0000;
      4'd2:    seg = 7'b110_1101;
      4'd3:    seg = 7'b111_1001;
      4'd4:    seg = 7'b011_0011;
      4'd5:    seg = 7'b101_1011;
      4'd6:    seg = 7'b101_1111;
      4'd7:    seg = 7'b111_0000;
      4'd8:    seg = 7'b111_1111;
      4'd9:    seg = 7'b111_1011;
      default: seg = 7'b000_0000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for a raw push-button level followed by a one-clock rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic s1_q, s2_q, s2_dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s2_dly_q <= 1'b0;
    end else begin
      s1_q     <= btn;
      s2_q     <= s1_q;
      s2_dly_q <= s2_q;
    end
  end

  assign pulse = s2_q & ~s2_dly_q;

endmodule

// File: rtl/lap_stopwatch.sv
// HH:MM:SS.CC stopwatch with run/pause/clear control and a registered 8-digit 7-segment scan.
// Define LAP_HOLD_EN to build the lap register and display hold.
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 1000,
  parameter int unsigned SCAN_DIV       = 1,
  parameter bit          COM_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       lap_btn,
  input  logic       clr_btn,
  output logic [7:0] seg_data,
  output logic [7:0] seg_com,
  output logic       running,
  output logic       overflow
);

  localparam int unsigned PrescCnt = CLK_HZ / 100;
  localparam int unsigned PrescW   = (PrescCnt > 1) ? $clog2(PrescCnt) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(PrescCnt - 1);
  localparam int unsigned DivW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);

  sw_state_e         state_q;
  logic [PrescW-1:0] presc_q;
  logic              ovf_q;
  logic [31:0]       time_q, time_d, time_inc, shown;
  logic              start_ev, clr_ev, tick, day_wrap;

  btn_sync_edge u_start (.clk(clk), .rst(rst), .btn(start_btn), .pulse(start_ev));
  btn_sync_edge u_clr   (.clk(clk), .rst(rst), .btn(clr_btn),   .pulse(clr_ev));

`ifdef LAP_HOLD_EN
  logic        lap_ev, hold_q;
  logic [31:0] lap_q;

  btn_sync_edge u_lap (.clk(clk), .rst(rst), .btn(lap_btn), .pulse(lap_ev));
  assign shown = hold_q ? lap_q : time_q;
`else
  logic unused_lap;
  assign unused_lap = lap_btn;
  assign shown      = time_q;
`endif

  assign tick = (state_q == StRun) && (presc_q == PrescMax);

  // BCD increment with the whole carry chain resolved in one cycle.
  always_comb begin
    logic carry;
    time_inc = time_q;
    day_wrap = 1'b0;
    carry    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (time_q[4*i +: 4] == LowDigitMax[4*i +: 4]) begin
          time_inc[4*i +: 4] = 4'd0;
        end else begin
          time_inc[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
    if (carry) begin
      if (time_q[31:28] == HourTenMax && time_q[27:24] == HourOneWrap) begin
        time_inc[31:24] = 8'h00;
        day_wrap        = 1'b1;
      end else if (time_q[27:24] == DecDigitMax) begin
        time_inc[27:24] = 4'd0;
        time_inc[31:28] = time_q[31:28] + 4'd1;
      end else begin
        time_inc[27:24] = time_q[27:24] + 4'd1;
      end
    end
  end

  always_comb begin
    time_d = time_q;
    unique case (state_q)
      StRun:           if (tick) time_d = time_inc;
      StIdle, StPause: if (clr_ev) time_d = '0;
      default:         time_d = time_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) time_q <= '0;
    else     time_q <= time_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      presc_q <= '0;
      ovf_q   <= 1'b0;
`ifdef LAP_HOLD_EN
      hold_q  <= 1'b0;
      lap_q   <= '0;
`endif
    end else begin
`ifdef LAP_HOLD_EN
      // The clear below is scheduled later, so PAUSE+clr wins over a coincident lap.
      if (lap_ev && state_q != StIdle) begin
        if (hold_q) begin
          hold_q <= 1'b0;
        end else begin
          hold_q <= 1'b1;
          lap_q  <= time_q;
        end
      end
`endif
      unique case (state_q)
        StIdle: begin
          if (clr_ev) begin
            presc_q <= '0;
            ovf_q   <= 1'b0;
          end else if (start_ev) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          presc_q <= tick ? '0 : presc_q + 1'b1;
          if (tick && day_wrap) ovf_q <= 1'b1;
          if (start_ev) state_q <= StPause;
        end
        StPause: begin
          if (clr_ev) begin
            state_q <= StIdle;
            presc_q <= '0;
            ovf_q   <= 1'b0;
`ifdef LAP_HOLD_EN
            hold_q  <= 1'b0;
`endif
          end else if (start_ev) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign running  = (state_q == StRun);
  assign overflow = ovf_q;

  logic [DivW-1:0] div_q;
  logic [2:0]      idx_q;
  logic [7:0]      seg_data_q, seg_com_q, cur_sel;
  logic [3:0]      cur_digit;
  logic            cur_dp;

  // Digit index 0 is h_ten, held in the top nibble of the time word.
  always_comb begin
    cur_digit = shown[{~idx_q, 2'b00} +: 4];
    cur_sel   = 8'h80 >> idx_q;
    cur_dp    = SepDpMask[~idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      idx_q      <= '0;
      seg_data_q <= 8'h00;
      seg_com_q  <= COM_ACTIVE_LOW ? 8'hFF : 8'h00;
    end else begin
      seg_data_q <= {bcd_to_seg(cur_digit), cur_dp};
      seg_com_q  <= COM_ACTIVE_LOW ? ~cur_sel : cur_sel;
      if (div_q == DivMax) begin
        div_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign seg_data = seg_data_q;
  assign seg_com  = seg_com_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: time kept as a centisecond count, display predicted from that count.
module tb_lap_stopwatch;

  localparam int ClkHz   = 1000;
  localparam int ScanDiv = 1;
  localparam int Presc   = ClkHz / 100;
  localparam int DayCs   = 24 * 60 * 60 * 100;
  localparam int MIdle = 0, MRun = 1, MPause = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_btn = 1'b0, lap_btn = 1'b0, clr_btn = 1'b0;
  logic [7:0] seg_data, seg_com;
  logic       running, overflow;

  int checks   = 0;
  int failures = 0;

  lap_stopwatch #(
    .CLK_HZ        (ClkHz),
    .SCAN_DIV      (ScanDiv),
    .COM_ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .lap_btn  (lap_btn),
    .clr_btn  (clr_btn),
    .seg_data (seg_data),
    .seg_com  (seg_com),
    .running  (running),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         m_st, m_pre, m_t, m_lap, m_div, m_idx;
  bit         m_ovf, m_hold;
  bit [2:0]   h_start, h_clr;
`ifdef LAP_HOLD_EN
  bit [2:0]   h_lap;
`endif
  logic [7:0] m_seg, m_com;

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int digit_at(input int t, input int idx);
    int h, m, s, c;
    c = t % 100;
    s = (t / 100) % 60;
    m = (t / 6000) % 60;
    h = t / 360000;
    case (idx)
      0: return h / 10;
      1: return h % 10;
      2: return m / 10;
      3: return m % 10;
      4: return s / 10;
      5: return s % 10;
      6: return c / 10;
      default: return c % 10;
    endcase
  endfunction

  task automatic model_clear();
    m_t = 0; m_pre = 0; m_ovf = 0; m_hold = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_st = MIdle; m_lap = 0; m_div = 0; m_idx = 0;
    h_start = '0; h_clr = '0;
`ifdef LAP_HOLD_EN
    h_lap = '0;
`endif
    m_seg = 8'h00; m_com = 8'hFF;
  endtask

  // One rising clock edge of the specified behaviour, using button levels sampled at that edge.
  task automatic model_edge();
    bit se, ce;
    int shown;
    se = h_start[1] & ~h_start[2];
    ce = h_clr[1] & ~h_clr[2];
    h_start = {h_start[1:0], start_btn};
    h_clr   = {h_clr[1:0], clr_btn};
    shown = m_hold ? m_lap : m_t;
    m_com = ~(8'h80 >> m_idx);
    m_seg = {seg7(digit_at(shown, m_idx)), (m_idx == 1 || m_idx == 3 || m_idx == 5)};
    if (m_div == ScanDiv - 1) begin
      m_div = 0;
      m_idx = (m_idx + 1) % 8;
    end else begin
      m_div++;
    end
`ifdef LAP_HOLD_EN
    if ((h_lap[1] & ~h_lap[2]) && m_st != MIdle) begin
      if (m_hold) m_hold = 0;
      else begin
        m_hold = 1;
        m_lap  = m_t;
      end
    end
    h_lap = {h_lap[1:0], lap_btn};
`endif
    case (m_st)
      MIdle: begin
        if (ce) model_clear();
        else if (se) m_st = MRun;
      end
      MRun: begin
        if (m_pre == Presc - 1) begin
          m_pre = 0;
          m_t++;
          if (m_t == DayCs) begin
            m_t   = 0;
            m_ovf = 1;
          end
        end else begin
          m_pre++;
        end
        if (se) m_st = MPause;
      end
      default: begin
        if (ce) begin
          m_st = MIdle;
          model_clear();
        end else if (se) m_st = MRun;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // High for one sample; the effect is visible when this returns.
  task automatic pulse(input bit s, input bit l, input bit c);
    start_btn = s; lap_btn = l; clr_btn = c;
    step();
    start_btn = 0; lap_btn = 0; clr_btn = 0;
    step();
    step();
  endtask

  // Scans all 8 digits off the display pins; -1 if a digit or select is unreadable.
  task automatic read_display(output int t);
    int dig[8];
    int idx, d;
    bit ok;
    ok = 1;
    for (int k = 0; k < 8; k++) dig[k] = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      idx = -1;
      d   = -1;
      for (int b = 0; b < 8; b++) if (seg_com == ~(8'h80 >> b)) idx = b;
      for (int v = 0; v < 10; v++) if (seg_data[7:1] == seg7(v)) d = v;
      if (idx >= 0) dig[idx] = d;
    end
    for (int k = 0; k < 8; k++) if (dig[k] < 0) ok = 0;
    t = ok ? (dig[0] * 10 + dig[1]) * 360000 + (dig[2] * 10 + dig[3]) * 6000 +
             (dig[4] * 10 + dig[5]) * 100 + dig[6] * 10 + dig[7] : -1;
  endtask

  task automatic test_reset();
    checks++;
    if (seg_data !== 8'h00) begin
      failures++; $display("FAIL reset_seg_data got=%h exp=00", seg_data);
    end
    checks++;
    if (seg_com !== 8'hFF) begin
      failures++; $display("FAIL reset_seg_com got=%h exp=FF", seg_com);
    end
    checks++;
    if (running !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b exp=00", running, overflow);
    end
  endtask

  task automatic test_scan();
    logic [7:0] walk [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] exp_data;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_data = (i == 1 || i == 3 || i == 5) ? 8'hFD : 8'hFC;
      checks++;
      if (seg_com !== walk[i] || seg_data !== exp_data) begin
        failures++;
        $display("FAIL scan_%0d com=%h data=%h exp com=%h data=%h", i, seg_com, seg_data,
                 walk[i], exp_data);
      end
    end
  endtask

  task automatic test_run_pause();
    int t;
    pulse(1, 0, 0);
    checks++;
    if (running !== 1'b1) begin
      failures++; $display("FAIL run_start running=%b exp=1", running);
    end
    repeat (997) step();
    pulse(1, 0, 0);
    checks++;
    if (running !== 1'b0) begin
      failures++; $display("FAIL run_pause running=%b exp=0", running);
    end
    read_display(t);
    checks++;
    if (t !== 100) begin
      failures++; $display("FAIL run_one_second time=%0d exp=100", t);
    end
    repeat (50) step();
    read_display(t);
    checks++;
    if (t !== 100) begin
      failures++; $display("FAIL run_frozen time=%0d exp=100", t);
    end
  endtask

  task automatic test_clr_in_run();
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    checks++;
    if (running !== 1'b1) begin
      failures++; $display("FAIL clr_in_run running=%b exp=1", running);
    end
    for (int k = 0; k < 40; k++) begin
      step();
      checks++;
      if (seg_data !== m_seg || seg_com !== m_com || overflow !== m_ovf) begin
        failures++;
        $display("FAIL clr_in_run_cyc%0d data=%h/%h com=%h/%h ovf=%b/%b", k, seg_data, m_seg,
                 seg_com, m_com, overflow, m_ovf);
      end
    end
  endtask

  task automatic test_pause_start_clr();
    int t;
    pulse(1, 0, 0);
    pulse(1, 0, 1);
    checks++;
    if (running !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL start_clr_flags got=%b%b exp=00", running, overflow);
    end
    read_display(t);
    checks++;
    if (t !== 0) begin
      failures++; $display("FAIL start_clr_time time=%0d exp=0", t);
    end
    // Prescaler must restart from zero: one hundredth after exactly Presc clocks.
    pulse(1, 0, 0);
    repeat (Presc - 3) step();
    pulse(1, 0, 0);
    read_display(t);
    checks++;
    if (t !== 1) begin
      failures++; $display("FAIL first_tick time=%0d exp=1", t);
    end
    pulse(0, 0, 1);
  endtask

  task automatic test_overflow();
    int t;
    pulse(1, 0, 0);
    repeat ($urandom_range(3, 20)) step();
    pulse(1, 0, 0);
    force dut.time_q = 32'h2359_5999;
    m_t = DayCs - 1;
    step();
    release dut.time_q;
    read_display(t);
    checks++;
    if (t !== DayCs - 1) begin
      failures++; $display("FAIL preload time=%0d exp=%0d", t, DayCs - 1);
    end
    pulse(1, 0, 0);
    for (int k = 0; k < 2 * Presc && m_pre != Presc - 3; k++) step();
    pulse(1, 0, 0);
    checks++;
    if (overflow !== 1'b1 || running !== 1'b0) begin
      failures++; $display("FAIL wrap_flags ovf/run=%b%b exp=10", overflow, running);
    end
    read_display(t);
    checks++;
    if (t !== 0) begin
      failures++; $display("FAIL wrap_time time=%0d exp=0", t);
    end
    pulse(0, 0, 1);
    checks++;
    if (overflow !== 1'b0 || running !== 1'b0) begin
      failures++; $display("FAIL wrap_clr ovf/run=%b%b exp=00", overflow, running);
    end
  endtask

  task automatic test_lap();
    int t;
    pulse(1, 0, 0);
`ifdef LAP_HOLD_EN
    for (int k = 0; k < 3000 && !(m_t == 250 && m_pre == 0); k++) step();
    pulse(0, 1, 0);
    for (int k = 0; k < 600 && m_t < 300; k++) begin
      step();
      checks++;
      if (seg_data !== m_seg || seg_com !== m_com) begin
        failures++;
        $display("FAIL lap_hold_cyc%0d data=%h/%h com=%h/%h", k, seg_data, m_seg, seg_com, m_com);
      end
    end
    read_display(t);
    checks++;
    if (t !== 250 || running !== 1'b1) begin
      failures++; $display("FAIL lap_frozen time=%0d run=%b exp=250 run=1", t, running);
    end
`else
    repeat (20) step();
`endif
    pulse(0, 1, 0);
    for (int k = 0; k < 30; k++) begin
      step();
      checks++;
      if (seg_data !== m_seg || seg_com !== m_com) begin
        failures++;
        $display("FAIL lap_live_cyc%0d data=%h/%h com=%h/%h", k, seg_data, m_seg, seg_com, m_com);
      end
    end
    pulse(1, 0, 0);
    pulse(0, 0, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 15) == 0) lap_btn = ~lap_btn;
      if ($urandom_range(0, 23) == 0) clr_btn = ~clr_btn;
      step();
      checks++;
      if (seg_data !== m_seg || seg_com !== m_com || running !== (m_st == MRun) ||
          overflow !== m_ovf) begin
        failures++;
        $display("FAIL random_cyc%0d data=%h/%h com=%h/%h run=%b/%b ovf=%b/%b", k, seg_data,
                 m_seg, seg_com, m_com, running, (m_st == MRun), overflow, m_ovf);
      end
    end
    start_btn = 0; lap_btn = 0; clr_btn = 0;
    repeat (4) step();
    if (m_st == MRun) pulse(1, 0, 0);
    if (m_st == MPause) pulse(0, 0, 1);
  endtask

  task automatic test_reset_mid();
    int t;
    pulse(1, 0, 0);
    for (int k = 0; k < 6000 && m_t < 537; k++) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (seg_data !== 8'h00 || seg_com !== 8'hFF || running !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid data=%h com=%h run=%b ovf=%b exp 00 FF 0 0", seg_data, seg_com,
               running, overflow);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    pulse(1, 0, 0);
    repeat (297) step();
    pulse(1, 0, 0);
    read_display(t);
    checks++;
    if (t !== 30) begin
      failures++; $display("FAIL reset_resume time=%0d exp=30", t);
    end
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1 test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_scan();
    test_run_pause();
    test_clr_in_run();
    test_pause_start_clr();
    test_overflow();
    test_lap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
